bitwise_logic_unit: RTL and testbench
=====================================

Name: bitwise_logic_unit

Overview:
- Parametrised, pipelined successor to the combinational 4-bit AND block.
- Implements eight bitwise operations on WIDTH-bit operands, selected per transaction by an opcode.
- Carries data through STAGES register stages with valid/ready handshake on both sides.
- Produces result flags (zero, all-ones, parity); sits in the ALU datapath beside the arithmetic units, feeding the result mux.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..64.
- STAGES, 2, pipeline register stages from input to output; legal values 1 or 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode valid this cycle.
- in_ready  output  1  block can accept a transaction this cycle.
- op  input  3  operation select, sampled with in_valid.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- ones  output  1  out == all ones.
- parity  output  1  XOR reduction of out.

Interface rule (already decided): one clock; reset is asynchronous and active-high. Clock is clk, reset is rst.

Behaviour:
- Opcodes:
  - 0 AND A&B; 1 OR A|B; 2 XOR A^B.
  - 3 NAND ~(A&B); 4 NOR ~(A|B); 5 XNOR ~(A^B).
  - 6 NOT ~A (B ignored); 7 PASS A (B ignored).
  - All eight codes are defined; no illegal opcodes.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global stall, no bubble compression:
  - adv = ~out_valid | out_ready.
  - in_ready = adv, combinational from out_valid/out_ready only, never from in_valid.
  - All stage registers (data and valid) load only when adv = 1.
- STAGES = 2:
  - Stage 1 registers A, B, op and valid.
  - Stage 2 registers the computed result, flags and valid.
  - Latency is 2 cycles from input transfer to out_valid with out_ready held high.
- STAGES = 1:
  - Result is computed combinationally from A/B/op and registered once.
  - Latency is 1 cycle.
- Throughput: one transaction per cycle while out_ready = 1.
- Bubbles: when in_valid = 0 and adv = 1, a valid = 0 bubble advances. Bubbles are not squeezed out during a stall.
- Output stability: while out_valid && !out_ready, out, flags and out_valid hold. Stage 1 also holds.
- Non-valid output: when out_valid = 0, out and the flags hold their last value (no X, unlike the legacy enable block).
- Flags:
  - Computed from the stage-final result and registered with it.
  - zero and ones are both 1 only if WIDTH = 0, which is illegal, so they are never both 1.
- Reset (asynchronous, any time including mid-stall):
  - All valid bits = 0.
  - out = 0, zero = 1, ones = 0, parity = 0.
  - Stage-1 data registers = 0.
  - In-flight transactions are dropped; nothing is emitted after reset deasserts until new input.
- Simultaneous events:
  - Input and output transfers in the same cycle are legal; the pipeline shifts.
  - in_valid while in_ready = 0 is not accepted. The source must hold it; the block does not capture it.
- Width: no truncation or extension; all operations are strictly WIDTH bits.

Optional Feature:
- Macro: BITWISE_LU_POPCOUNT_EN.
- Defined:
  - Adds output port popcnt, width $clog2(WIDTH+1), equal to the number of 1 bits in out.
  - Computed in the final stage and registered alongside out and the flags.
  - Reset value 0; holds under stall exactly like out.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then opcode sweep (WIDTH = 4, STAGES = 2, out_ready = 1):
  - Stimulus: A = 4'b1100, B = 4'b1010, op 0..7 on consecutive cycles.
  - Expected out two cycles after each input: 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1100.
  - out_valid stays high for 8 consecutive cycles.
- Flags: AND 4'b0101 & 4'b1010 -> out = 0000, zero = 1, parity = 0. OR of the same -> out = 1111, ones = 1, parity = 0. XOR 4'b0001 ^ 0 -> parity = 1.
- Backpressure:
  - Stimulus: stream 3 ops, with out_ready = 0 from the cycle the first result appears.
  - Expected: out, flags and out_valid hold; in_ready = 0.
  - Raise out_ready for 3 cycles: the 3 results emerge in order with no loss or duplicate.
- Async reset mid-stall: assert rst between clock edges with 2 transactions in flight -> out_valid = 0, out = 0, zero = 1 immediately, before the next clk edge. After release, no stale result appears.
- STAGES = 1, WIDTH = 8: NAND 8'hF0, 8'h3C -> out = 8'hCF one cycle after transfer. Back-to-back inputs give one result per cycle.
- BITWISE_LU_POPCOUNT_EN defined, WIDTH = 8: XOR 8'hFF, 8'h0F -> out = 8'hF0, popcnt = 4. PASS 8'hFF -> popcnt = 8.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: eight ops on WIDTH-bit operands, 1 or 2 stages, valid/ready both sides.
// Define BITWISE_LU_POPCOUNT_EN to add a registered popcnt output.
module bitwise_logic_unit #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
`ifdef BITWISE_LU_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] popcnt,
`endif
    output logic             parity
);

    localparam int PCW = $clog2(WIDTH + 1);

    logic             adv;
    logic [WIDTH-1:0] f_a;
    logic [WIDTH-1:0] f_b;
    logic [2:0]       f_op;
    logic             f_v;
    logic [WIDTH-1:0] res;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;
`ifdef BITWISE_LU_POPCOUNT_EN
    logic [PCW-1:0]   popcnt_q, popcnt_d;
`endif

    function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

`ifdef BITWISE_LU_POPCOUNT_EN
    function automatic logic [PCW-1:0] count_ones(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction
`endif

    // Global stall: every stage moves together, so a stalled output freezes the whole pipe.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    generate
        if (STAGES == 2) begin : g_stage1
            logic [WIDTH-1:0] a_q, a_d;
            logic [WIDTH-1:0] b_q, b_d;
            logic [2:0]       op_q, op_d;
            logic             v1_q, v1_d;

            // Data registers only reload on a real transaction so bubbles leave them untouched.
            always_comb begin
                a_d  = a_q;
                b_d  = b_q;
                op_d = op_q;
                v1_d = v1_q;
                if (adv) begin
                    v1_d = in_valid;
                    if (in_valid) begin
                        a_d  = A;
                        b_d  = B;
                        op_d = op;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    op_q <= '0;
                    v1_q <= 1'b0;
                end else begin
                    a_q  <= a_d;
                    b_q  <= b_d;
                    op_q <= op_d;
                    v1_q <= v1_d;
                end
            end

            assign f_a  = a_q;
            assign f_b  = b_q;
            assign f_op = op_q;
            assign f_v  = v1_q;
        end else begin : g_direct
            assign f_a  = A;
            assign f_b  = B;
            assign f_op = op;
            assign f_v  = in_valid;
        end
    endgenerate

    assign res = logic_op(f_a, f_b, f_op);

    // Result and flags hold their last value across bubbles, so out never goes unknown.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
`ifdef BITWISE_LU_POPCOUNT_EN
        popcnt_d    = popcnt_q;
`endif
        if (adv) begin
            out_valid_d = f_v;
            if (f_v) begin
                out_d    = res;
                zero_d   = ~|res;
                ones_d   = &res;
                parity_d = ^res;
`ifdef BITWISE_LU_POPCOUNT_EN
                popcnt_d = count_ones(res);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
`ifdef BITWISE_LU_POPCOUNT_EN
            popcnt_q    <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
`ifdef BITWISE_LU_POPCOUNT_EN
            popcnt_q    <= popcnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign parity    = parity_q;
`ifdef BITWISE_LU_POPCOUNT_EN
    assign popcnt    = popcnt_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: a WIDTH=4/STAGES=2 instance and a WIDTH=8/STAGES=1 instance.
// Checks popcnt as well when BITWISE_LU_POPCOUNT_EN is defined.
module tb_bitwise_logic_unit;

    typedef struct {
        logic [7:0] out;
        logic       z;
        logic       o;
        logic       p;
        logic [3:0] pc;
    } exp_t;

    logic clk;
    logic rst;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [2:0] op4;
    logic [3:0] a4, b4, out4;
    logic       zero4, ones4, parity4;
    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0] op8;
    logic [7:0] a8, b8, out8;
    logic       zero8, ones8, parity8;
`ifdef BITWISE_LU_POPCOUNT_EN
    logic [2:0] popcnt4;
    logic [3:0] popcnt8;
`endif

    int total = 0;
    int bad   = 0;
    int run4 = 0, max4 = 0, pops4 = 0;
    int run8 = 0, max8 = 0;
    exp_t sb4[$];
    exp_t sb8[$];

    bitwise_logic_unit #(.WIDTH(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .op(op4), .A(a4), .B(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
        .zero(zero4), .ones(ones4),
`ifdef BITWISE_LU_POPCOUNT_EN
        .popcnt(popcnt4),
`endif
        .parity(parity4)
    );

    bitwise_logic_unit #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
        .zero(zero8), .ones(ones8),
`ifdef BITWISE_LU_POPCOUNT_EN
        .popcnt(popcnt8),
`endif
        .parity(parity8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] v, input logic [7:0] all_ones, input logic [3:0] pc);
        exp_t e;
        e.out = v;
        e.z   = (v == 8'h00);
        e.o   = (v == all_ones);
        e.p   = ^v;
        e.pc  = pc;
        return e;
    endfunction

    // Monitors: pop and compare whenever the DUT hands over a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid4) run4++; else run4 = 0;
        if (run4 > max4) max4 = run4;
        if (!rst && out_valid4 && out_ready4) begin
            pops4++;
            if (sb4.size() == 0) begin
                total++; bad++;
                $display("FAIL mon4_unexpected: got out=%0h expected no output", out4);
            end else begin
                e = sb4.pop_front();
                check("mon4_out", 64'(out4), 64'(e.out[3:0]));
                check("mon4_zero", 64'(zero4), 64'(e.z));
                check("mon4_ones", 64'(ones4), 64'(e.o));
                check("mon4_parity", 64'(parity4), 64'(e.p));
`ifdef BITWISE_LU_POPCOUNT_EN
                check("mon4_popcnt", 64'(popcnt4), 64'(e.pc));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid8) run8++; else run8 = 0;
        if (run8 > max8) max8 = run8;
        if (!rst && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                total++; bad++;
                $display("FAIL mon8_unexpected: got out=%0h expected no output", out8);
            end else begin
                e = sb8.pop_front();
                check("mon8_out", 64'(out8), 64'(e.out));
                check("mon8_zero", 64'(zero8), 64'(e.z));
                check("mon8_ones", 64'(ones8), 64'(e.o));
                check("mon8_parity", 64'(parity8), 64'(e.p));
`ifdef BITWISE_LU_POPCOUNT_EN
                check("mon8_popcnt", 64'(popcnt8), 64'(e.pc));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge with in_valid dropped.
    task automatic send4(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp, input logic [3:0] pc);
        int n;
        n = 0;
        in_valid4 = 1'b1; op4 = o; a4 = a; b4 = b;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) begin
            total++; bad++;
            $display("FAIL send4_timeout: got in_ready=0 expected 1");
        end else begin
            sb4.push_back(mk({4'h0, exp}, 8'h0F, pc));
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input logic [3:0] pc);
        int n;
        n = 0;
        in_valid8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready8) begin
            total++; bad++;
            $display("FAIL send8_timeout: got in_ready=0 expected 1");
        end else begin
            sb8.push_back(mk(exp, 8'hFF, pc));
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sweep [8];
        logic [3:0] sweep_pc [8];
        int base;
        sweep    = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        sweep_pc = '{4'd1, 4'd3, 4'd2, 4'd3, 4'd1, 4'd2, 4'd2, 4'd2};

        rst = 1'b1;
        in_valid4 = 0; op4 = 0; a4 = 0; b4 = 0; out_ready4 = 1;
        in_valid8 = 0; op8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
        #2;
        check("rst_out_valid", 64'(out_valid4), 64'd0);
        check("rst_out", 64'(out4), 64'd0);
        check("rst_zero", 64'(zero4), 64'd1);
        check("rst_ones", 64'(ones4), 64'd0);
        check("rst_parity", 64'(parity4), 64'd0);
        check("rst_out8", 64'(out8), 64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Opcode sweep with A=1100, B=1010
        max4 = 0;
        for (int i = 0; i < 8; i++) begin
            send4(3'(i), 4'b1100, 4'b1010, sweep[i], sweep_pc[i]);
            if (i == 0) check("lat2_not_yet", 64'(out_valid4), 64'd0);
            if (i == 1) begin
                check("lat2_valid", 64'(out_valid4), 64'd1);
                check("lat2_out", 64'(out4), 64'b1000);
            end
        end
        repeat (4) begin @(posedge clk); #1; end
        check("sweep_valid_run", 64'(max4), 64'd8);
        check("sweep_drained", 64'(sb4.size()), 64'd0);
        check("idle_hold_out", 64'(out4), 64'b1100);

        // Flags
        send4(3'd0, 4'b0101, 4'b1010, 4'b0000, 4'd0);
        @(posedge clk); #1;
        check("flag_and_out", 64'(out4), 64'd0);
        check("flag_and_zero", 64'(zero4), 64'd1);
        check("flag_and_parity", 64'(parity4), 64'd0);
        send4(3'd1, 4'b0101, 4'b1010, 4'b1111, 4'd4);
        @(posedge clk); #1;
        check("flag_or_out", 64'(out4), 64'hF);
        check("flag_or_ones", 64'(ones4), 64'd1);
        check("flag_or_zero", 64'(zero4), 64'd0);
        check("flag_or_parity", 64'(parity4), 64'd0);
        send4(3'd2, 4'b0001, 4'b0000, 4'b0001, 4'd1);
        @(posedge clk); #1;
        check("flag_xor_parity", 64'(parity4), 64'd1);
        repeat (2) begin @(posedge clk); #1; end

        // Backpressure: third op waits at the input while the output stalls
        out_ready4 = 1;
        send4(3'd0, 4'b0011, 4'b0101, 4'b0001, 4'd1);
        out_ready4 = 0;
        send4(3'd1, 4'b0011, 4'b0101, 4'b0111, 4'd3);
        fork
            send4(3'd2, 4'b0011, 4'b0101, 4'b0110, 4'd2);
        join_none
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(out_valid4), 64'd1);
            check("stall_out", 64'(out4), 64'b0001);
            check("stall_parity", 64'(parity4), 64'd1);
            check("stall_zero", 64'(zero4), 64'd0);
            check("stall_in_ready", 64'(in_ready4), 64'd0);
            @(posedge clk); #1;
        end
        base = pops4;
        out_ready4 = 1;
        repeat (3) begin @(posedge clk); #1; end
        check("bp_pop_count", 64'(pops4 - base), 64'd3);
        check("bp_drained", 64'(sb4.size()), 64'd0);
        check("bp_empty_after", 64'(out_valid4), 64'd0);

        // Async reset mid-stall with two in flight
        send4(3'd6, 4'b1001, 4'b0000, 4'b0110, 4'd2);
        out_ready4 = 0;
        send4(3'd7, 4'b0101, 4'b0000, 4'b0101, 4'd2);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid4), 64'd0);
        check("arst_out", 64'(out4), 64'd0);
        check("arst_zero", 64'(zero4), 64'd1);
        check("arst_parity", 64'(parity4), 64'd0);
        sb4.delete();
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        out_ready4 = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("no_stale", 64'(out_valid4), 64'd0);
        end
        send4(3'd2, 4'b0001, 4'b0000, 4'b0001, 4'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("post_rst_drained", 64'(sb4.size()), 64'd0);

        // STAGES=1, WIDTH=8
        max8 = 0;
        send8(3'd3, 8'hF0, 8'h3C, 8'hCF, 4'd6);
        check("lat1_valid", 64'(out_valid8), 64'd1);
        check("lat1_out", 64'(out8), 64'hCF);
        send8(3'd0, 8'hF0, 8'h3C, 8'h30, 4'd2);
        send8(3'd1, 8'hF0, 8'h3C, 8'hFC, 4'd6);
        send8(3'd2, 8'hF0, 8'h3C, 8'hCC, 4'd4);
        send8(3'd5, 8'hF0, 8'h3C, 8'h33, 4'd4);
        send8(3'd4, 8'hF0, 8'h3C, 8'h03, 4'd2);
        send8(3'd6, 8'hF0, 8'h3C, 8'h0F, 4'd4);
        send8(3'd2, 8'hFF, 8'h0F, 8'hF0, 4'd4);
        send8(3'd7, 8'hFF, 8'h00, 8'hFF, 4'd8);
        check("pass_ones8", 64'(ones8), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        check("b2b_valid_run8", 64'(max8), 64'd9);
        check("b2b_drained8", 64'(sb8.size()), 64'd0);
        check("final_drained4", 64'(sb4.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
